// File: rtl/bus_breakin_if.sv
// Handshake and unpacked-field bundle for the bus_breakin receive FIFO.
// The slave view is the FIFO itself; the master view is the producer/consumer side.
interface bus_breakin_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [5:0]                 in_word;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_in2_hi;
    logic [1:0]                 out_and;
    logic [1:0]                 out_in1_lo;
    logic [$clog2(DEPTH):0]     level;
    logic [CNT_W-1:0]           and_cnt;

    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_in2_hi,
        output out_and,
        output out_in1_lo,
        output level,
        output and_cnt
    );

    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_in2_hi,
        input  out_and,
        input  out_in1_lo,
        input  level,
        input  and_cnt
    );
endinterface

// File: rtl/bus_breakin.sv
// Receive-side FIFO for packed 6-bit breakout words: buffers, unpacks into the
// three 2-bit fields, and counts popped words whose AND field is non-zero.
module bus_breakin #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_breakin_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [CNT_W-1:0] and_cnt_q;
    logic [5:0]       head;
    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             pop;

    // Handshake flags depend on the level counter only, so a full FIFO refuses
    // a push even when a pop happens on the same edge.
    assign not_full  = (level_q != LVL_FULL);
    assign not_empty = (level_q != '0);
    assign push      = bus.in_valid && not_full;
    assign pop       = bus.out_ready && not_empty;
    assign head      = mem[rd_ptr];

    assign bus.in_ready   = not_full;
    assign bus.out_valid  = not_empty;
    assign bus.level      = level_q;
    assign bus.and_cnt    = and_cnt_q;
    assign bus.out_in2_hi = not_empty ? head[5:4] : 2'b00;
    assign bus.out_and    = not_empty ? head[3:2] : 2'b00;
    assign bus.out_in1_lo = not_empty ? head[1:0] : 2'b00;

    // Storage needs no reset: the fields are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            and_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if ((head[3:2] != 2'b00) && (and_cnt_q != CNT_MAX)) begin
                    and_cnt_q <= and_cnt_q + CNT_ONE;
                end
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule
